cache_miss_buffer: RTL

CACHE_MISS_BUFFER -- requirements
Module: cache_miss_buffer

---
 rtl/cache_miss_buffer_pkg.sv | 12 +
 rtl/cache_miss_buffer_entry.sv | 64 ++++++
 rtl/cache_miss_buffer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cache_miss_buffer_pkg.sv
// Shared types for the cache miss buffer.
package cache_miss_buffer_pkg;

   // Lifecycle of one outstanding-miss entry
   typedef enum logic [1:0] {
      MB_FREE   = 2'd0,
      MB_ISSUE  = 2'd1,
      MB_WAIT   = 2'd2,
      MB_REFILL = 2'd3
   } mb_state_e;

endpackage

// File: rtl/cache_miss_buffer_entry.sv
// One outstanding-miss entry: state, line address, dirty flag and line buffer.
module cache_miss_buffer_entry
   import cache_miss_buffer_pkg::*;
#(
   parameter int unsigned PA_BITS = 56,
   parameter int unsigned LINELEN = 512
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_alloc,
   input  logic               i_merge,
   input  logic [PA_BITS-1:0] i_line_adr,
   input  logic               i_write,
   input  logic               i_issue_done,
   input  logic               i_fill,
   input  logic [LINELEN-1:0] i_fill_data,
   input  logic               i_refill_done,
   output mb_state_e          o_state,
   output logic [PA_BITS-1:0] o_adr,
   output logic               o_dirty,
   output logic [LINELEN-1:0] o_data
);

   mb_state_e          r_state;
   mb_state_e          w_state_next;
   logic [PA_BITS-1:0] r_adr;
   logic               r_dirty;
   logic [LINELEN-1:0] r_data;

   // State register; reset frees the entry immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= MB_FREE;
      else       r_state <= w_state_next;
   end

   // Next-state: FREE -> ISSUE -> WAIT -> REFILL -> FREE
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         MB_FREE:   if (i_alloc)       w_state_next = MB_ISSUE;
         MB_ISSUE:  if (i_issue_done)  w_state_next = MB_WAIT;
         MB_WAIT:   if (i_fill)        w_state_next = MB_REFILL;
         MB_REFILL: if (i_refill_done) w_state_next = MB_FREE;
         default:                      w_state_next = MB_FREE;
      endcase
   end

   // Payload storage survives reset; a merge only ever raises dirty
   always_ff @(posedge clk) begin
      if (i_alloc) begin
         r_adr   <= i_line_adr;
         r_dirty <= i_write;
      end else if (i_merge) begin
         r_dirty <= r_dirty | i_write;
      end
      if (i_fill) r_data <= i_fill_data;
   end

   assign o_state = r_state;
   assign o_adr   = r_adr;
   assign o_dirty = r_dirty;
   assign o_data  = r_data;

endmodule

// File: rtl/cache_miss_buffer.sv
// Outstanding-miss buffer: merges same-line misses, issues line fetches, returns refills.
module cache_miss_buffer
   import cache_miss_buffer_pkg::*;
#(
   parameter int unsigned PA_BITS    = 56,
   parameter int unsigned LINELEN    = 512,
   parameter int unsigned NUMENTRIES = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          MissValid,
   input  logic [PA_BITS-1:0]            MissAdr,
   input  logic                          MissWrite,
   output logic                          MissReady,
   output logic [$clog2(NUMENTRIES)-1:0] MissId,
   input  logic                          FlushStage,
   output logic                          BusReqValid,
   output logic [PA_BITS-1:0]            BusReqAdr,
   output logic [$clog2(NUMENTRIES)-1:0] BusReqId,
   input  logic                          BusReqReady,
   input  logic                          FillValid,
   input  logic [$clog2(NUMENTRIES)-1:0] FillId,
   input  logic [LINELEN-1:0]            FillData,
   output logic                          RefillValid,
   output logic [PA_BITS-1:0]            RefillAdr,
   output logic [LINELEN-1:0]            RefillData,
   output logic                          RefillDirty,
   input  logic                          RefillReady,
   output logic                          Full,
   output logic                          Empty
);

   localparam int unsigned ID_W = $clog2(NUMENTRIES);
   localparam logic [PA_BITS-1:0] OFF_MASK = PA_BITS'(LINELEN / 8 - 1);

   // Lowest set bit as a one-hot vector
   function automatic logic [NUMENTRIES-1:0] lowest_one_hot(input logic [NUMENTRIES-1:0] v);
      return v & (~v + NUMENTRIES'(1));
   endfunction

   // One-hot to index via AND-OR
   function automatic logic [ID_W-1:0] one_hot_to_id(input logic [NUMENTRIES-1:0] v);
      logic [ID_W-1:0] id;
      id = '0;
      for (int i = 0; i < NUMENTRIES; i++) id = id | ({ID_W{v[i]}} & ID_W'(i));
      return id;
   endfunction

   mb_state_e          w_state [NUMENTRIES];
   logic [PA_BITS-1:0] w_adr   [NUMENTRIES];
   logic [LINELEN-1:0] w_data  [NUMENTRIES];
   logic [NUMENTRIES-1:0] w_dirty;
   logic [NUMENTRIES-1:0] w_free, w_issue, w_wait, w_refill, w_hit, w_refill_hit;
   logic [NUMENTRIES-1:0] w_alloc_oh, w_issue_oh, w_refill_oh;
   logic [NUMENTRIES-1:0] w_alloc, w_merge, w_issue_done, w_fill, w_refill_done;
   logic [PA_BITS-1:0]    w_miss_line;
   logic                  w_any_hit, w_accept;

   assign w_miss_line = MissAdr & ~OFF_MASK;

   // Per-entry state decode and line-address match
   always_comb begin
      w_free = '0; w_issue = '0; w_wait = '0; w_refill = '0;
      w_hit = '0; w_refill_hit = '0; w_fill = '0;
      for (int i = 0; i < NUMENTRIES; i++) begin
         w_free[i]       = (w_state[i] == MB_FREE);
         w_issue[i]      = (w_state[i] == MB_ISSUE);
         w_wait[i]       = (w_state[i] == MB_WAIT);
         w_refill[i]     = (w_state[i] == MB_REFILL);
         w_hit[i]        = (w_issue[i] | w_wait[i]) & (w_adr[i] == w_miss_line);
         w_refill_hit[i] = w_refill[i] & (w_adr[i] == w_miss_line);
         w_fill[i]       = FillValid & (FillId == ID_W'(i)) & w_wait[i];
      end
   end

   assign w_alloc_oh  = lowest_one_hot(w_free);
   assign w_issue_oh  = lowest_one_hot(w_issue);
   assign w_refill_oh = lowest_one_hot(w_refill);

   // Miss acceptance: merge into a pending fetch, else allocate unless the line is mid-refill
   assign w_any_hit = |w_hit;
   assign MissReady = w_any_hit | (~|w_refill_hit & |w_free);
   assign MissId    = w_any_hit ? one_hot_to_id(w_hit) : one_hot_to_id(w_alloc_oh);
   assign w_accept  = MissValid & MissReady & ~FlushStage;
   assign w_merge   = {NUMENTRIES{w_accept}} & w_hit;
   assign w_alloc   = {NUMENTRIES{w_accept & ~w_any_hit}} & w_alloc_oh;

   assign w_issue_done  = w_issue_oh & {NUMENTRIES{BusReqReady}};
   assign w_refill_done = w_refill_oh & {NUMENTRIES{RefillReady}};

   // Entry storage
   for (genvar g = 0; g < NUMENTRIES; g++) begin : g_entry
      cache_miss_buffer_entry #(
         .PA_BITS (PA_BITS),
         .LINELEN (LINELEN)
      ) u_entry (
         .clk           (clk),
         .reset         (reset),
         .i_alloc       (w_alloc[g]),
         .i_merge       (w_merge[g]),
         .i_line_adr    (w_miss_line),
         .i_write       (MissWrite),
         .i_issue_done  (w_issue_done[g]),
         .i_fill        (w_fill[g]),
         .i_fill_data   (FillData),
         .i_refill_done (w_refill_done[g]),
         .o_state       (w_state[g]),
         .o_adr         (w_adr[g]),
         .o_dirty       (w_dirty[g]),
         .o_data        (w_data[g])
      );
   end

   // AND-OR selection of the bus-request and refill payloads
   always_comb begin
      BusReqAdr   = '0;
      RefillAdr   = '0;
      RefillData  = '0;
      RefillDirty = 1'b0;
      for (int i = 0; i < NUMENTRIES; i++) begin
         BusReqAdr   = BusReqAdr  | ({PA_BITS{w_issue_oh[i]}}  & w_adr[i]);
         RefillAdr   = RefillAdr  | ({PA_BITS{w_refill_oh[i]}} & w_adr[i]);
         RefillData  = RefillData | ({LINELEN{w_refill_oh[i]}} & w_data[i]);
         RefillDirty = RefillDirty | (w_refill_oh[i] & w_dirty[i]);
      end
   end

   assign BusReqValid = |w_issue;
   assign BusReqId    = one_hot_to_id(w_issue_oh);
   assign RefillValid = |w_refill;
   assign Full        = ~|w_free;
   assign Empty       = &w_free;

endmodule
